// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the 8-bit processor control path: instruction field
// positions, opcode encodings, sequencer states and small decode helpers.
package proc_pkg;

    // Instruction word layout; imm deliberately overlaps rs.
    localparam int OPC_MSB = 7;
    localparam int OPC_LSB = 5;
    localparam int RS_MSB  = 4;
    localparam int RS_LSB  = 3;
    localparam int IMM_MSB = 4;
    localparam int IMM_LSB = 0;

    // Opcode encodings; 0xx are ALU operations.
    localparam logic [2:0] OP_STORE = 3'b100;
    localparam logic [2:0] OP_JMP   = 3'b101;
    localparam logic [2:0] OP_BRZ   = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXECUTE,
        WRITEBACK,
        HALTED,
        FAULT
    } state_t;

    // Sign-extend the 5-bit relative offset to PC width (-16..+15).
    function automatic logic [7:0] sext_imm(input logic [4:0] imm);
        return {{3{imm[4]}}, imm};
    endfunction

    // ALU operations are identified by a clear opcode MSB.
    function automatic logic is_alu_op(input logic [2:0] op);
        return ~op[2];
    endfunction

endpackage

// File: rtl/fetch_sequencer_pc_next.sv
// Combinational next-PC: either a plain increment or a sign-extended
// relative add. Arithmetic wraps modulo 256; range checking is done by the
// sequencer when the PC is next used for a fetch.
module pc_next
    import proc_pkg::*;
(
    input  logic [7:0] pc,
    input  logic [4:0] imm,
    input  logic       take_rel,
    output logic [7:0] next_pc
);

    // Select relative target or sequential successor.
    always_comb begin
        if (take_rel) begin
            next_pc = pc + sext_imm(imm);
        end else begin
            next_pc = pc + 8'd1;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Multi-cycle control sequencer: owns the program counter and instruction
// register, and steps each instruction through FETCH, DECODE, EXECUTE and
// (for ALU ops) WRITEBACK, issuing one-cycle enable strobes. All strobes and
// status flags are decoded from the registered state only.
module fetch_sequencer
    import proc_pkg::*;
#(
    parameter int MEM_DEPTH = 11
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       run,
    input  logic [7:0] instr_in,
    input  logic       instr_valid,
    input  logic       zero_flag,
    output logic [7:0] pccounter,
    output logic [7:0] ir,
    output logic [2:0] opcode,
    output logic [1:0] rs,
    output logic [4:0] imm,
    output logic       alu_en,
    output logic       mem_we,
    output logic       reg_we,
    output logic       halted,
    output logic       fault
);

    // Depth expressed at PC width so the range compare is width-matched.
    localparam logic [7:0] DEPTH_LIMIT = 8'(MEM_DEPTH);

    state_t     state;
    state_t     next_state;
    logic [7:0] pc_succ;
    logic       take_rel;
    logic       pc_in_range;
    logic       ir_load;
    logic       pc_load;

    // Field slices of the latched instruction.
    assign opcode = ir[OPC_MSB:OPC_LSB];
    assign rs     = ir[RS_MSB:RS_LSB];
    assign imm    = ir[IMM_MSB:IMM_LSB];

    assign pc_in_range = (pccounter < DEPTH_LIMIT);

    // Relative target taken for JMP always, BRZ only with zero flag set.
    // Outside EXECUTE this is don't-care because the PC is not loaded.
    assign take_rel = (state == EXECUTE) &&
                      ((opcode == OP_JMP) || ((opcode == OP_BRZ) && zero_flag));

    // Instruction register accepts only an in-range, valid fetch.
    assign ir_load = (state == FETCH) && pc_in_range && instr_valid;

    // PC moves only when leaving EXECUTE or when a HALT leaves DECODE.
    assign pc_load = (state == EXECUTE) ||
                     ((state == DECODE) && (opcode == OP_HALT));

    pc_next u_pc_next (
        .pc       (pccounter),
        .imm      (imm),
        .take_rel (take_rel),
        .next_pc  (pc_succ)
    );

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Program counter and instruction register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pccounter <= 8'd0;
            ir        <= 8'd0;
        end else begin
            if (pc_load) begin
                pccounter <= pc_succ;
            end
            if (ir_load) begin
                ir <= instr_in;
            end
        end
    end

    // Next-state decode.
    always_comb begin
        // NOTE: default assignment first so no path leaves next_state
        // unassigned, which would otherwise infer a latch.
        next_state = state;
        unique case (state)
            IDLE: begin
                if (run) begin
                    next_state = FETCH;
                end
            end
            FETCH: begin
                // Range check takes priority over instr_valid.
                if (!pc_in_range) begin
                    next_state = FAULT;
                end else if (instr_valid) begin
                    next_state = DECODE;
                end
            end
            DECODE: begin
                if (opcode == OP_HALT) begin
                    next_state = HALTED;
                end else begin
                    next_state = EXECUTE;
                end
            end
            EXECUTE: begin
                if (is_alu_op(opcode)) begin
                    next_state = WRITEBACK;
                end else begin
                    next_state = FETCH;
                end
            end
            WRITEBACK: begin
                next_state = FETCH;
            end
            HALTED: begin
                if (run) begin
                    next_state = FETCH;
                end
            end
            FAULT: begin
                next_state = FAULT;
            end
            default: begin
                next_state = FAULT;
            end
        endcase
    end

    // Moore output decode from registered state.
    always_comb begin
        alu_en = 1'b0;
        mem_we = 1'b0;
        reg_we = 1'b0;
        halted = 1'b0;
        fault  = 1'b0;
        unique case (state)
            IDLE:      halted = 1'b1;
            HALTED:    halted = 1'b1;
            FAULT:     fault  = 1'b1;
            EXECUTE: begin
                alu_en = is_alu_op(opcode);
                mem_we = (opcode == OP_STORE);
            end
            WRITEBACK: reg_we = 1'b1;
            default: begin
                alu_en = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a small instruction memory feeds
// instr_in from pccounter, and each step compares outputs against
// hand-computed values one time unit after the rising edge.
module tb_fetch_sequencer;

    logic       clock;
    logic       reset_n;
    logic       run;
    logic [7:0] instr_in;
    logic       instr_valid;
    logic       zero_flag;
    logic [7:0] pccounter;
    logic [7:0] ir;
    logic [2:0] opcode;
    logic [1:0] rs;
    logic [4:0] imm;
    logic       alu_en;
    logic       mem_we;
    logic       reg_we;
    logic       halted;
    logic       fault;

    logic [7:0] mem [0:15];
    int tests_run;
    int tests_failed;

    fetch_sequencer #(.MEM_DEPTH(11)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .run         (run),
        .instr_in    (instr_in),
        .instr_valid (instr_valid),
        .zero_flag   (zero_flag),
        .pccounter   (pccounter),
        .ir          (ir),
        .opcode      (opcode),
        .rs          (rs),
        .imm         (imm),
        .alu_en      (alu_en),
        .mem_we      (mem_we),
        .reg_we      (reg_we),
        .halted      (halted),
        .fault       (fault)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Combinational instruction memory read.
    assign instr_in = (pccounter < 8'd16) ? mem[pccounter[3:0]] : 8'h00;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Strobe/status vector {alu_en, mem_we, reg_we, halted, fault}.
    function automatic logic [7:0] flags();
        return {3'b000, alu_en, mem_we, reg_we, halted, fault};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        mem[0] = 8'b000_01_011;   // ALU op
        mem[1] = 8'b100_00000;    // STORE
        mem[2] = 8'b111_00000;    // HALT
        mem[3] = 8'b110_11110;    // BRZ -2
        mem[4] = 8'b101_01111;    // JMP +15

        reset_n     = 1'b0;
        run         = 1'b0;
        instr_valid = 1'b1;
        zero_flag   = 1'b0;
        #12;
        check("reset_pc", pccounter, 8'h00);
        check("reset_ir", ir, 8'h00);
        check("reset_flags", flags(), 8'b0000_0010);
        reset_n = 1'b1;

        tick();
        check("idle_no_run", flags(), 8'b0000_0010);

        // ALU op at address 0.
        run = 1'b1;
        tick();                                    // FETCH
        run = 1'b0;
        check("alu_fetch_flags", flags(), 8'h00);
        check("alu_fetch_pc", pccounter, 8'h00);
        tick();                                    // DECODE
        check("alu_decode_ir", ir, 8'h0B);
        check("alu_opcode", {5'd0, opcode}, 8'h00);
        check("alu_rs", {6'd0, rs}, 8'h01);
        check("alu_imm", {3'd0, imm}, 8'h0B);
        check("alu_decode_flags", flags(), 8'h00);
        tick();                                    // EXECUTE
        check("alu_exec_flags", flags(), 8'b0001_0000);
        check("alu_exec_pc", pccounter, 8'h00);
        instr_valid = 1'b0;
        tick();                                    // WRITEBACK
        check("alu_wb_flags", flags(), 8'b0000_0100);
        check("alu_wb_pc", pccounter, 8'h01);

        // FETCH stalled three cycles at pc=1.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_pc", pccounter, 8'h01);
            check("stall_ir", ir, 8'h0B);
            check("stall_flags", flags(), 8'h00);
        end
        instr_valid = 1'b1;
        tick();                                    // DECODE
        check("store_decode_ir", ir, 8'h80);
        tick();                                    // EXECUTE
        check("store_exec_flags", flags(), 8'b0000_1000);
        tick();                                    // FETCH
        check("store_next_pc", pccounter, 8'h02);
        check("store_fetch_flags", flags(), 8'h00);

        // HALT at pc=2.
        tick();                                    // DECODE
        check("halt_decode_ir", ir, 8'hE0);
        check("halt_decode_pc", pccounter, 8'h02);
        check("halt_decode_flags", flags(), 8'h00);
        tick();                                    // HALTED
        check("halted_flags", flags(), 8'b0000_0010);
        check("halted_pc", pccounter, 8'h03);
        tick();
        check("halted_hold", flags(), 8'b0000_0010);

        // Resume: BRZ taken from pc=3 back to 1.
        run = 1'b1;
        tick();                                    // FETCH
        run = 1'b0;
        check("resume_flags", flags(), 8'h00);
        check("resume_pc", pccounter, 8'h03);
        tick();                                    // DECODE
        check("brz_ir", ir, 8'hDE);
        check("brz_opcode", {5'd0, opcode}, 8'h06);
        check("brz_imm", {3'd0, imm}, 8'h1E);
        tick();                                    // EXECUTE
        zero_flag = 1'b1;
        check("brz_exec_flags", flags(), 8'h00);
        tick();                                    // FETCH
        zero_flag = 1'b0;
        check("brz_taken_pc", pccounter, 8'h01);

        // STORE at 1, HALT at 2, resume, BRZ not taken.
        tick(); tick(); tick();                    // DECODE, EXECUTE, FETCH
        check("loop_pc2", pccounter, 8'h02);
        tick(); tick();                            // DECODE, HALTED
        check("loop_halted_pc", pccounter, 8'h03);
        run = 1'b1;
        tick();                                    // FETCH
        run = 1'b0;
        tick(); tick(); tick();                    // DECODE, EXECUTE, FETCH
        check("brz_not_taken_pc", pccounter, 8'h04);

        // JMP +15 from 4 lands at 19, faulting at the next FETCH.
        tick();                                    // DECODE
        check("jmp_ir", ir, 8'hAF);
        tick();                                    // EXECUTE
        check("jmp_exec_pc", pccounter, 8'h04);
        tick();                                    // FETCH out of range
        check("jmp_target_pc", pccounter, 8'h13);
        check("jmp_fetch_flags", flags(), 8'h00);
        tick();                                    // FAULT
        check("fault_flags", flags(), 8'b0000_0001);
        run = 1'b1;
        tick(); tick();
        check("fault_sticky_flags", flags(), 8'b0000_0001);
        check("fault_pc_frozen", pccounter, 8'h13);
        check("fault_ir_frozen", ir, 8'hAF);
        run = 1'b0;

        // Reset mid-WRITEBACK applies without a clock edge.
        reset_n = 1'b0;
        #3;
        reset_n = 1'b1;
        run = 1'b1;
        tick();                                    // FETCH
        run = 1'b0;
        tick(); tick(); tick();                    // DECODE, EXECUTE, WRITEBACK
        check("pre_reset_reg_we", flags(), 8'b0000_0100);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_pc", pccounter, 8'h00);
        check("async_reset_ir", ir, 8'h00);
        check("async_reset_flags", flags(), 8'b0000_0010);
        #20;
        check("held_reset_flags", flags(), 8'b0000_0010);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Multi-cycle control sequencer for the 8-bit processor. It owns the program counter that addresses the instruction memory and latches the fetched instruction into an instruction register. It splits that register into opcode, Rs and immediate fields, and steps each instruction through FETCH, DECODE, EXECUTE and optional WRITEBACK, issuing one-cycle enable strobes to the ALU, register file and data memory.

## Interface
- MEM_DEPTH, 11: number of valid instruction words; a PC ≥ MEM_DEPTH is a fault.
- clock  in  1  rising-edge system clock.
- reset_n  in  1  asynchronous, active-low reset.
- run  in  1  start from IDLE / resume from HALTED (level, sampled each cycle).
- instr_in  in  8  instruction word at `pccounter`; combinational read from instruction memory.
- instr_valid  in  1  instr_in is valid this cycle.
- zero_flag  in  1  ALU zero flag, sampled in EXECUTE.
- pccounter  out  8  program counter / instruction memory address.
- ir  out  8  latched instruction.
- opcode  out  3  ir[7:5].
- rs  out  2  ir[4:3].
- imm  out  5  ir[4:0]; overlaps rs by design.
- alu_en  out  1  one-cycle pulse in EXECUTE for ALU ops (opcode 0xx).
- mem_we  out  1  one-cycle pulse in EXECUTE for STORE (100).
- reg_we  out  1  one-cycle pulse in WRITEBACK (ALU ops only).
- halted  out  1  high in IDLE and HALTED.
- fault  out  1  high in FAULT.

## Operation
- Opcodes: 0xx ALU op (writeback); 100 STORE; 101 JMP (relative, unconditional); 110 BRZ (relative, taken iff zero_flag=1); 111 HALT.
- Reset (async, any state): state=IDLE; pccounter=0, ir=0; alu_en, mem_we, reg_we, fault = 0; halted=1.
- IDLE: run=1 → FETCH.
- FETCH: if instr_valid=0, stay; pccounter and ir hold.
  - If pccounter ≥ MEM_DEPTH → FAULT. This check runs before instr_valid is considered.
  - Otherwise, on instr_valid=1: ir ← instr_in, → DECODE.
- DECODE: one cycle, no strobes.
  - opcode 111 → HALTED, with pccounter ← pccounter+1.
  - Any other opcode → EXECUTE.
- EXECUTE: one cycle; alu_en or mem_we pulses per opcode. PC update at the end of the cycle:
  - pccounter ← pccounter + sext(imm) for JMP, or for BRZ with zero_flag=1.
  - pccounter ← pccounter + 1 otherwise.
  - Next state: ALU op → WRITEBACK; all others → FETCH.
- WRITEBACK: reg_we=1 for one cycle → FETCH.
- HALTED: halted=1; run=1 → FETCH, continuing at the stored pccounter.
- FAULT: fault=1, all strobes 0, pccounter frozen; exit only via reset.
- Arithmetic: 8-bit, modulo 256. sext(imm) = {{3{imm[4]}}, imm}, range −16..+15.
  - Wrap below 0 (e.g. 1 − 2 = 255) is legal arithmetic; it lands in FAULT at the next FETCH.
- Simultaneous events:
  - run is ignored outside IDLE and HALTED.
  - zero_flag is ignored outside EXECUTE.
  - instr_valid is ignored outside FETCH.

## Timing
- Strobes and halted/fault are Moore outputs decoded from registered state, glitch-free and valid the whole cycle.
- opcode, rs and imm are combinational slices of ir; they are stable from DECODE until the next FETCH accepts.
- Latency with instr_valid already high:
  - ALU op: 4 cycles (FETCH→DECODE→EXECUTE→WRITEBACK).
  - STORE/JMP/BRZ: 3 cycles.
  - HALT: 2 cycles to HALTED.
- Each FETCH cycle with instr_valid=0 adds exactly one cycle.
- pccounter changes only on the clock edge leaving EXECUTE or DECODE(HALT).

## Structure
- Package `proc_pkg`:
  - opcode localparams OP_STORE=3'b100, OP_JMP=3'b101, OP_BRZ=3'b110, OP_HALT=3'b111;
  - state enum {IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALTED, FAULT};
  - field positions (OPC 7:5, RS 4:3, IMM 4:0).
- One sub-module, `pc_next`: combinational next-PC (increment / sign-extended relative add). All state lives in fetch_sequencer.

## Test plan
- Reset mid-WRITEBACK → pccounter=0, ir=0, halted=1, reg_we=0 immediately, without waiting for a clock edge.
- mem[0]=8'b000_01_011, run pulse → alu_en in the 3rd cycle after FETCH entry, reg_we in the 4th; rs=2'b01, imm=5'b01011, pccounter=1.
- instr_valid held low 3 cycles in FETCH → state, pccounter and ir unchanged; the instruction completes 3 cycles late.
- BRZ 8'b110_11110 at pc=3 → zero_flag=1 gives pccounter=1; zero_flag=0 gives pccounter=4.
- HALT at pc=2 → halted=1, pccounter=3; run=1 resumes fetch at address 3.
- JMP with imm=+15 from pc=0, or pc reaching 11 → FAULT at next FETCH; fault=1, pccounter frozen, no strobes until reset.
